// File: rtl/rr_arb_dec8_if.sv
// rtl/rr_arb_dec8_if.sv - request/grant bundle between requesters and rr_arb_dec8
//
// Signals:
//   req      [7:0]  request vector, bit i = requester i wants the resource
//   done            current owner releases the resource
//   gnt      [7:0]  one-hot grant, 1<<gnt_idx while gnt_vld, else 0
//   gnt_idx  [2:0]  index of current owner (decoder select)
//   gnt_vld         grant active (decoder enable)
//   timeout         one-cycle pulse after a grant was revoked by hold expiry
//
// Modports:
//   master  arbiter side, drives the grant outputs
//   slave   requester side, drives req/done
`timescale 1ns/1ps

interface rr_arb_dec8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );
endinterface

// File: rtl/rr_arb_dec8.sv
// rtl/rr_arb_dec8.sv - eight-way round-robin arbiter with decoder-form grant and hold timeout
//
// Parameters:
//   HOLD_MAX  maximum consecutive cycles one grant may stay asserted (1..255)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arb_dec8_if.master: req/done in, gnt/gnt_idx/gnt_vld/timeout out
//
// Every output comes from a register; gnt is a pure decode of the registered
// gnt_idx/gnt_vld, so nothing on req or done reaches an output in the same cycle.
`timescale 1ns/1ps

module rr_arb_dec8 #(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arb_dec8_if.master    bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] ptr;
    logic [2:0] next_ptr;
    logic [7:0] cnt;
    logic [7:0] next_cnt;
    logic [2:0] idx_r;
    logic [2:0] next_idx;
    logic       timeout_r;
    logic       next_timeout;

    // Rotating priority search: first set request starting at ptr, wrapping 7->0.
    logic [2:0] winner;
    logic       winner_found;
    logic [2:0] cand;

    always_comb begin
        winner       = 3'd0;
        winner_found = 1'b0;
        cand         = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!winner_found && bus.req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            idx_r     <= 3'd0;
            timeout_r <= 1'b0;
        end else begin
            state     <= next_state;
            ptr       <= next_ptr;
            cnt       <= next_cnt;
            idx_r     <= next_idx;
            timeout_r <= next_timeout;
        end
    end

    always_comb begin
        next_state   = state;
        next_ptr     = ptr;
        next_cnt     = cnt;
        next_idx     = idx_r;
        next_timeout = 1'b0;
        case (state)
            IDLE: begin
                // done is deliberately not looked at here.
                if (winner_found) begin
                    next_state = GRANT;
                    next_idx   = winner;
                    next_cnt   = 8'd0;
                    next_ptr   = winner + 3'd1;
                end
            end
            GRANT: begin
                // A voluntary release wins over expiry, so done on the last
                // allowed cycle never raises timeout.
                if (bus.done || !bus.req[idx_r]) begin
                    next_state = IDLE;
                end else if (cnt == HOLD_LAST) begin
                    next_state   = IDLE;
                    next_timeout = 1'b1;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // gnt_idx keeps the last owner after release; only gnt_vld qualifies it.
    assign bus.gnt_idx = idx_r;
    assign bus.gnt_vld = (state == GRANT);
    assign bus.timeout = timeout_r;
    assign bus.gnt     = (state == GRANT) ? (8'd1 << idx_r) : 8'h00;

endmodule

// File: tb/tb_rr_arb_dec8.sv
// tb/tb_rr_arb_dec8.sv - directed self-checking bench for rr_arb_dec8
`timescale 1ns/1ps

module tb_rr_arb_dec8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    rr_arb_dec8_if bus ();

    rr_arb_dec8 #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout} !== 13'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc%0d: gnt=%h idx=%0d vld=%b to=%b, want all 0",
                         i, bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_first_grant: gnt=%h idx=%0d vld=%b, want 01 0 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_vld, bus.timeout} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_release: gnt=%h vld=%b to=%b, want 00 0 0",
                     bus.gnt, bus.gnt_vld, bus.timeout);
        end
    endtask

    task automatic test_rr_sweep();
        logic [2:0] exp_idx;
        // Fresh reset so the pointer starts at 0.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_idx = 3'(i % 8);
            tick();
            tests_run++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout} !==
                {8'd1 << exp_idx, exp_idx, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL sweep_grant #%0d: gnt=%h idx=%0d vld=%b to=%b, want idx %0d",
                         i, bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout, exp_idx);
            end
            tick();
            tests_run++;
            if ({bus.gnt, bus.gnt_vld, bus.timeout} !== 10'd0) begin
                tests_failed++;
                $display("FAIL sweep_idle #%0d: gnt=%h vld=%b to=%b, want 00 0 0",
                         i, bus.gnt, bus.gnt_vld, bus.timeout);
            end
        end
        // ptr now 1
    endtask

    task automatic test_ptr_wrap();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h20;
        exp_seq[1] = 8'h02;
        exp_seq[2] = 8'h20;
        exp_seq[3] = 8'h02;
        bus.done = 1'b1;
        bus.req  = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.gnt, bus.gnt_vld} !== {exp_seq[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL wrap_grant #%0d: gnt=%h vld=%b, want %h 1",
                         i, bus.gnt, bus.gnt_vld, exp_seq[i]);
            end
            bus.req = 8'h22;
            tick();
            tests_run++;
            if (bus.gnt !== 8'h00) begin
                tests_failed++;
                $display("FAIL wrap_idle #%0d: gnt=%h, want 00", i, bus.gnt);
            end
        end
        bus.req = 8'h00;
        // ptr now 2
    endtask

    task automatic test_timeout();
        bus.done = 1'b0;
        bus.req  = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.gnt, bus.timeout} !== {8'h08, 1'b0}) begin
                tests_failed++;
                $display("FAIL timeout_hold cyc%0d: gnt=%h to=%b, want 08 0",
                         i, bus.gnt, bus.timeout);
            end
        end
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_vld, bus.timeout, bus.gnt_idx} !== {8'h00, 1'b0, 1'b1, 3'd3}) begin
            tests_failed++;
            $display("FAIL timeout_pulse: gnt=%h vld=%b to=%b idx=%0d, want 00 0 1 3",
                     bus.gnt, bus.gnt_vld, bus.timeout, bus.gnt_idx);
        end
        tick();
        tests_run++;
        if ({bus.gnt, bus.timeout} !== {8'h08, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_regrant: gnt=%h to=%b, want 08 0", bus.gnt, bus.timeout);
        end
        // Ride to the last allowed cycle, then release with done on it.
        tick();
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        tests_run++;
        if ({bus.gnt, bus.timeout} !== {8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL done_at_limit: gnt=%h to=%b, want 00 0", bus.gnt, bus.timeout);
        end
        bus.req  = 8'h00;
        bus.done = 1'b0;
        // ptr now 4
    endtask

    task automatic test_req_drop();
        bus.done = 1'b0;
        bus.req  = 8'h04;
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h04, 3'd2}) begin
            tests_failed++;
            $display("FAIL drop_grant: gnt=%h idx=%0d, want 04 2", bus.gnt, bus.gnt_idx);
        end
        bus.req = 8'h40;
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_vld, bus.timeout} !== 10'd0) begin
            tests_failed++;
            $display("FAIL drop_release: gnt=%h vld=%b to=%b, want 00 0 0",
                     bus.gnt, bus.gnt_vld, bus.timeout);
        end
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h40, 3'd6, 1'b1}) begin
            tests_failed++;
            $display("FAIL drop_next: gnt=%h idx=%0d vld=%b, want 40 6 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        // ptr now 7
    endtask

    task automatic test_async_reset();
        bus.req = 8'h10;
        tick();
        tests_run++;
        if (bus.gnt !== 8'h10) begin
            tests_failed++;
            $display("FAIL arst_setup: gnt=%h, want 10", bus.gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.gnt, bus.gnt_vld, bus.timeout, bus.gnt_idx} !== 13'd0) begin
            tests_failed++;
            $display("FAIL arst_immediate: gnt=%h vld=%b to=%b idx=%0d, want all 0",
                     bus.gnt, bus.gnt_vld, bus.timeout, bus.gnt_idx);
        end
        bus.req = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL arst_ptr_reset: gnt=%h idx=%0d vld=%b to=%b, want 01 0 1 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.req      = 8'h00;
        bus.done     = 1'b0;
        test_reset();
        test_rr_sweep();
        test_ptr_wrap();
        test_timeout();
        test_req_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_arb_dec8.md
# rr_arb_dec8

Eight-way round-robin arbiter that shares a single downstream resource between eight requesters and drives the resource select in decoder form. It has two outputs for the winner: a 3-bit index with a valid/enable, and the matching one-hot grant word (a 3-to-8 decode with enable). The block sits in front of any shared resource that is selected by the team's 3-to-8 decoder. It registers all outputs and bounds each ownership with a hold timeout.

## Interface
Parameters:
- HOLD_MAX, default 8: maximum number of consecutive cycles one grant may stay asserted; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  current owner releases the resource; sampled only while a grant is active.
- gnt  output  8  one-hot grant; equals 1<<gnt_idx when gnt_vld=1, else 8'h00.
- gnt_idx  output  3  index of current owner (decoder select input).
- gnt_vld  output  1  a grant is active (decoder enable).
- timeout  output  1  one-cycle pulse: the previous grant was revoked by HOLD_MAX expiry.

## Operation
- Two states: IDLE (gnt_vld=0) and GRANT (gnt_vld=1).
- Internal state: 3-bit priority pointer ptr and an 8-bit hold counter cnt.
- IDLE behaviour at each edge:
  - If req == 0, stay IDLE.
  - Otherwise, the winner is the first set bit of req, searching ptr, ptr+1, … with wrap 7→0.
  - Next state is GRANT, with gnt_idx=winner, gnt_vld=1, cnt=0, and ptr=(winner+1) mod 8.
- GRANT behaviour at each edge, by priority:
  1. done=1 or req[gnt_idx]=0: release to IDLE, timeout=0.
  2. Otherwise, cnt == HOLD_MAX-1: forced release to IDLE, timeout=1 for exactly one cycle.
  3. Otherwise, stay GRANT with cnt=cnt+1.
- On release:
  - gnt_vld and gnt clear.
  - gnt_idx holds its last value, but is meaningful only when gnt_vld=1.
  - ptr is unchanged.
- done is ignored in IDLE. Requests arriving during GRANT never preempt the owner.
- After any release, ptr already points past the last owner, so every continuously requesting port is served within 8 grants. This is the starvation-free guarantee.
- gnt is derived from registered gnt_idx/gnt_vld only, with no combinational path from req or done.
- timeout is 0 in every cycle except the IDLE cycle immediately following a forced release.

## Timing
- Reset (rst_n=0, asynchronous, takes effect without a clock edge):
  - State IDLE.
  - gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0.
  - ptr=0, cnt=0.
- Reset deassertion: the first rising edge with rst_n=1 performs normal IDLE arbitration.
- Grant latency: req seen at IDLE edge k means gnt is valid after edge k, so it is visible during cycle k+1.
- Release latency: done (or a request drop) seen at edge m means gnt is low after edge m.
- There is always at least one IDLE cycle between two grants; back-to-back ownership changes are never gapless.
- Maximum grant length: gnt is high for at most HOLD_MAX consecutive cycles. With HOLD_MAX=1, every grant lasts exactly 1 cycle unless it is released earlier.
- Simultaneous done=1 and cnt==HOLD_MAX-1: treated as a normal release, so timeout=0.
- Reset asserted mid-grant: outputs clear immediately and ptr returns to 0; no timeout pulse.

## Test plan
- Reset:
  - Stimulus: rst_n=0 with req=8'hFF for 3 cycles, then release reset.
  - Required: all outputs 0 during reset.
  - Required: the first edge after release gives gnt=8'h01, gnt_idx=0, gnt_vld=1.
- Round-robin sweep:
  - Stimulus: req=8'hFF held; done=1 in the first cycle of each grant.
  - Required: gnt_idx sequence 0,1,2,3,4,5,6,7,0.
  - Required: gnt alternates one grant cycle with one idle cycle; timeout stays 0.
- Pointer wrap:
  - Stimulus: grant and release port 5 (ptr=6); then req=8'h22 held with done pulsed per grant.
  - Required: next grant is gnt=8'h02 (idx 1), then 8'h20 (idx 5), then 8'h02.
- Timeout:
  - Stimulus: HOLD_MAX=4; req=8'h08 held; done=0.
  - Required: gnt=8'h08 for exactly 4 cycles, then one cycle with gnt=8'h00 and timeout=1.
  - Required: gnt=8'h08 again on the following edge.
- Request drop:
  - Stimulus: grant to idx 2; deassert req[2] with done=0.
  - Required: gnt=8'h00 after the next edge; timeout=0.
  - Required: a pending req[6] is granted on the edge after that.
- Asynchronous reset mid-grant:
  - Stimulus: while gnt=8'h10, pulse rst_n low between clock edges.
  - Required: gnt, gnt_vld and timeout go 0 immediately, before the next edge.
  - Required: after release with req=8'hFF, the grant goes to idx 0 (ptr was reset).
